// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the read-DMA arbiter: state encoding,
// beat-size constants and the dword-length to beat-count conversion.
package dma_arb_pkg;

  localparam logic [1:0] LP_ST_IDLE  = 2'd0;
  localparam logic [1:0] LP_ST_REQ   = 2'd1;
  localparam logic [1:0] LP_ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = LP_ST_IDLE,
    ST_REQ   = LP_ST_REQ,
    ST_DRAIN = LP_ST_DRAIN
  } arb_state_e;

  localparam int LP_DW_PER_BEAT = 4;
  localparam int LP_MAX_BEATS   = 256;

  // A zero length field means a full 1024-dword read; partial last beats round up.
  function automatic logic [8:0] len_to_beats(input logic [9:0] len);
    logic [10:0] dwords;
    if (len == '0) return 9'(LP_MAX_BEATS);
    dwords = {1'b0, len};
    return 9'((dwords + 11'(LP_DW_PER_BEAT - 1)) / 11'(LP_DW_PER_BEAT));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin after the last grant, or fixed
// lowest-index priority when DMA_READ_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int p_paths = 2
) (
  input  logic [p_paths-1:0] req,
  input  logic [p_paths-1:0] last,
  output logic [p_paths-1:0] grant
);

`ifdef DMA_READ_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    grant = '0;
    for (int i = p_paths - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`else
  int   last_idx;
  logic found;

  // Search offsets 1..p_paths from the last winner so it gets lowest priority.
  always_comb begin
    last_idx = 0;
    for (int i = 0; i < p_paths; i++) begin
      if (last[i]) last_idx = i;
    end
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= p_paths; k++) begin
      for (int i = 0; i < p_paths; i++) begin
        if (!found && req[i] && (i == (last_idx + k) % p_paths)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/dma_read_arbiter.sv
// Read-DMA arbiter: grants one client the engine port from request until done
// and the last beat. DMA_READ_ARB_FIXED_PRIO_EN selects fixed priority.
//   state | meaning
//   IDLE  | no grant, choose next pending path
//   REQ   | request held to engine, waiting for done
//   DRAIN | done seen, delivering remaining beats
module dma_read_arbiter
  import dma_arb_pkg::*;
#(
  parameter int p_paths  = 2,
  parameter int p_data_w = 128
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [p_paths*32-1:0]         ar_dma_read_addr,
  input  logic [p_paths*10-1:0]         ar_dma_read_len,
  input  logic [p_paths-1:0]            ar_dma_read_pending,
  output logic [p_paths-1:0]            ar_dma_read_done,
  output logic [p_paths*p_data_w-1:0]   ar_dma_read_data,
  output logic [p_paths-1:0]            ar_dma_read_data_valid,
  input  logic [p_paths-1:0]            ar_dma_read_data_ready,
  output logic [31:0]                   dma_read_addr,
  output logic [9:0]                    dma_read_len,
  output logic                          dma_read_pending,
  input  logic                          dma_read_done,
  input  logic [p_data_w-1:0]           dma_read_data,
  input  logic                          dma_read_data_valid,
  output logic                          dma_read_data_ready,
  output logic [p_paths-1:0]            o_grant
);

  arb_state_e          state_q, state_d;
  logic [p_paths-1:0]  grant_q, grant_d;
  logic [p_paths-1:0]  last_q;
  logic [31:0]         addr_q, addr_d;
  logic [9:0]          len_q, len_d;
  logic                pend_q, pend_d;
  logic [8:0]          beats_q, beats_d;
  logic                done_flag_q, done_flag_d;

  logic [p_paths-1:0]  sel;
  logic [31:0]         sel_addr;
  logic [9:0]          sel_len;
  logic                beat_hs;
  logic [8:0]          beats_left;

  rr_arbiter #(.p_paths(p_paths)) u_arb (
    .req   (ar_dma_read_pending),
    .last  (last_q),
    .grant (sel)
  );

`ifdef DMA_READ_ARB_FIXED_PRIO_EN
  assign last_q = '0;
`else
  logic [p_paths-1:0] last_d;
  assign last_d = (state_q == ST_IDLE && |sel) ? sel : last_q;

  // Reset points at the top path so path 0 wins first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) last_q <= p_paths'(1) << (p_paths - 1);
    else          last_q <= last_d;
  end
`endif

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < p_paths; i++) begin
      if (sel[i]) begin
        sel_addr = ar_dma_read_addr[i*32 +: 32];
        sel_len  = ar_dma_read_len[i*10 +: 10];
      end
    end
  end

  // Handshakes once the counter is exhausted are ignored so it never wraps.
  assign beat_hs    = dma_read_data_valid && dma_read_data_ready && (beats_q != '0);
  assign beats_left = beat_hs ? beats_q - 9'd1 : beats_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    len_d       = len_q;
    pend_d      = pend_q;
    beats_d     = beats_q;
    done_flag_d = done_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (|sel) begin
          state_d = ST_REQ;
          grant_d = sel;
          addr_d  = sel_addr;
          len_d   = sel_len;
          pend_d  = 1'b1;
          beats_d = len_to_beats(sel_len);
        end
      end
      ST_REQ: begin
        beats_d = beats_left;
        if (dma_read_done) begin
          pend_d      = 1'b0;
          done_flag_d = 1'b1;
          if (beats_left == '0) begin
            state_d     = ST_IDLE;
            grant_d     = '0;
            done_flag_d = 1'b0;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        beats_d = beats_left;
        if (beats_left == '0) begin
          state_d     = ST_IDLE;
          grant_d     = '0;
          done_flag_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        pend_d      = 1'b0;
        done_flag_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      pend_q      <= 1'b0;
      beats_q     <= '0;
      done_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      pend_q      <= pend_d;
      beats_q     <= beats_d;
      done_flag_q <= done_flag_d;
    end
  end

  assign o_grant                = grant_q;
  assign dma_read_addr          = addr_q;
  assign dma_read_len           = len_q;
  assign dma_read_pending       = pend_q;
  assign dma_read_data_ready    = |(ar_dma_read_data_ready & grant_q);
  assign ar_dma_read_data_valid = grant_q & {p_paths{dma_read_data_valid}};
  assign ar_dma_read_done       = grant_q & {p_paths{dma_read_done && state_q == ST_REQ && !done_flag_q}};
  assign ar_dma_read_data       = {p_paths{dma_read_data}};

endmodule

// File: tb/tb_dma_read_arbiter.sv
// Randomized bench for dma_read_arbiter against a transaction-level model of
// arbitration order, beat counts and done/data ordering.
module tb_dma_read_arbiter;

  localparam int P  = 3;
  localparam int DW = 128;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [P*32-1:0]   ar_addr;
  logic [P*10-1:0]   ar_len;
  logic [P-1:0]      ar_pend;
  logic [P-1:0]      ar_done;
  logic [P*DW-1:0]   ar_data;
  logic [P-1:0]      ar_valid;
  logic [P-1:0]      ar_ready;
  logic [31:0]       dma_addr;
  logic [9:0]        dma_len;
  logic              dma_pend;
  logic              dma_done;
  logic [DW-1:0]     dma_data;
  logic              dma_valid;
  logic              dma_ready;
  logic [P-1:0]      grant;

  int n_checks = 0;
  int n_errors = 0;
  int rr_last  = P - 1;

  dma_read_arbiter #(.p_paths(P), .p_data_w(DW)) dut (
    .i_clk                  (i_clk),
    .i_rst_n                (i_rst_n),
    .ar_dma_read_addr       (ar_addr),
    .ar_dma_read_len        (ar_len),
    .ar_dma_read_pending    (ar_pend),
    .ar_dma_read_done       (ar_done),
    .ar_dma_read_data       (ar_data),
    .ar_dma_read_data_valid (ar_valid),
    .ar_dma_read_data_ready (ar_ready),
    .dma_read_addr          (dma_addr),
    .dma_read_len           (dma_len),
    .dma_read_pending       (dma_pend),
    .dma_read_done          (dma_done),
    .dma_read_data          (dma_data),
    .dma_read_data_valid    (dma_valid),
    .dma_read_data_ready    (dma_ready),
    .o_grant                (grant)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [P-1:0] pend);
`ifdef DMA_READ_ARB_FIXED_PRIO_EN
    for (int i = 0; i < P; i++) if (pend[i]) return i;
`else
    for (int k = 1; k <= P; k++) if (pend[(rr_last + k) % P]) return (rr_last + k) % P;
`endif
    return -1;
  endfunction

  function automatic int exp_beats(input logic [9:0] l);
    int dwords;
    dwords = (l == 0) ? 1024 : int'(l);
    return (dwords + 3) / 4;
  endfunction

  task automatic set_req(input int p, input logic [31:0] a, input logic [9:0] l);
    ar_addr[p*32 +: 32] = a;
    ar_len[p*10 +: 10]  = l;
  endtask

  // Called at an IDLE cycle with the client requests already driven.
  // mode: 0 done before data, 1 done after k beats, 2 done with last beat, 3 done after all.
  task automatic serve_one(input int mode, input int stall_at, input int abort_after, input bit drop_mid);
    int g, beats, hs, k, stall_left;
    bit done_sent, stall_done, finished;
    logic [P-1:0] oh;
    logic [31:0]  exp_addr;
    logic [9:0]   exp_len;
    g = pick(ar_pend);
    #1;
    check_eq("pend_before_grant", dma_pend, 1'b0);
    oh       = P'(1) << g;
    rr_last  = g;
    exp_addr = ar_addr[g*32 +: 32];
    exp_len  = ar_len[g*10 +: 10];
    beats    = exp_beats(exp_len);
    k        = $urandom_range(0, beats - 1);
    hs = 0; done_sent = 0; stall_done = 0; stall_left = 0; finished = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge i_clk);
      dma_valid = (hs < beats || mode == 3) && ($urandom_range(0, 3) != 0);
      dma_data  = {$urandom, $urandom, $urandom, $urandom};
      ar_ready  = P'($urandom);
      dma_done  = 1'b0;
      if (drop_mid && cyc == 1) ar_pend = ar_pend & ~oh;
      if (stall_at >= 0 && !stall_done && hs == stall_at) begin
        stall_left = 10;
        stall_done = 1;
      end
      if (stall_left > 0) begin
        ar_ready  = ar_ready & ~oh;
        dma_valid = 1'b1;
        stall_left--;
      end
      if (!done_sent) begin
        case (mode)
          0: if (cyc == 0) begin dma_done = 1'b1; dma_valid = 1'b0; end
          1: if (hs == k) dma_done = 1'b1;
          2: if (hs == beats - 1) begin dma_done = 1'b1; dma_valid = 1'b1; ar_ready = ar_ready | oh; end
          default: if (hs == beats) dma_done = 1'b1;
        endcase
      end
      #1;
      check_eq("grant", grant, oh);
      check_eq("engine_req", {dma_pend, dma_addr, dma_len}, {!done_sent, exp_addr, exp_len});
      check_eq("engine_ready", dma_ready, |(ar_ready & oh));
      check_eq("client_valid", ar_valid, dma_valid ? oh : '0);
      check_eq("client_done", ar_done, dma_done ? oh : '0);
      if (dma_valid) check_eq("client_data", ar_data[g*DW +: DW], dma_data);
      if (dma_valid && |(ar_ready & oh) && hs < beats) hs++;
      if (dma_done) done_sent = 1;
      if (abort_after >= 0 && hs == abort_after) begin
        @(posedge i_clk);
        #1;
        dma_valid = 1'b1;
        ar_ready  = '1;
        i_rst_n   = 1'b0;
        #1;
        check_eq("abort_grant", grant, '0);
        check_eq("abort_outputs", {dma_pend, dma_addr, dma_len, dma_ready, ar_valid, ar_done}, '0);
        rr_last = P - 1;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        return;
      end
      if (done_sent && hs == beats) begin
        finished = 1;
        break;
      end
    end
    if (!finished) check_eq("xfer_timeout", 32'(hs), 32'(beats));
    @(negedge i_clk);
    dma_done  = 1'b0;
    dma_valid = 1'($urandom_range(0, 1));
    ar_ready  = '1;
    #1;
    check_eq("idle_grant", grant, '0);
    check_eq("idle_backpressure", {dma_pend, dma_ready, ar_valid}, '0);
  endtask

  initial begin
    i_rst_n   = 1'b0;
    ar_addr   = '0;
    ar_len    = '0;
    ar_pend   = '0;
    ar_ready  = '1;
    dma_done  = 1'b0;
    dma_data  = '0;
    dma_valid = 1'b1;
    repeat (2) @(negedge i_clk);
    #1;
    check_eq("reset_grant", grant, '0);
    check_eq("reset_outputs", {dma_pend, dma_addr, dma_len, dma_ready, ar_valid, ar_done}, '0);
    @(negedge i_clk);
    i_rst_n   = 1'b1;
    dma_valid = 1'b0;

    set_req(0, 32'h1000, 10'd16);
    ar_pend = 3'b001;
    serve_one(1, -1, -1, 0);
    ar_pend = '0;

    set_req(0, 32'h2000, 10'd8);
    set_req(1, 32'h3000, 10'd8);
    ar_pend = 3'b011;
    for (int i = 0; i < 3; i++) serve_one($urandom_range(0, 3), -1, -1, 0);
    ar_pend = '0;

    set_req(2, 32'hABC0, 10'd0);
    ar_pend = 3'b100;
    serve_one(0, -1, -1, 0);
    set_req(1, 32'h5550, 10'd0);
    ar_pend = 3'b010;
    serve_one(3, -1, -1, 0);

    set_req(0, 32'h7700, 10'd5);
    ar_pend = 3'b001;
    serve_one(2, -1, -1, 0);

    set_req(1, 32'h8800, 10'd16);
    ar_pend = 3'b010;
    serve_one(3, 1, -1, 1);

    set_req(0, 32'h9900, 10'd16);
    ar_pend = 3'b001;
    serve_one(3, -1, 2, 0);
    set_req(1, 32'hAA00, 10'd16);
    ar_pend = 3'b010;
    serve_one(1, -1, -1, 0);

    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < P; p++)
        set_req(p, $urandom, ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 40)));
      ar_pend = P'($urandom_range(1, (1 << P) - 1));
      serve_one($urandom_range(0, 3), ($urandom_range(0, 4) == 0) ? 0 : -1, -1, 1'($urandom_range(0, 1)));
    end
    ar_pend = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
